alu_operand_stage: RTL



---
 rtl/alu_operand_stage.sv | 113 +++++++++++
 1 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: RV32I decode/issue register feeding the ALU operands with a valid/ready handshake.
// Optional writeback bypass into the operand mux is enabled by defining ALU_OPERAND_FWD_EN.
module alu_operand_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [31:0]           instr_in,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [DATA_W-1:0]     rs1_data_in,
  input  logic [DATA_W-1:0]     rs2_data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic                  flush_in,
  input  logic                  fwd_valid_in,
  input  logic [REG_ADDR_W-1:0] fwd_rd_in,
  input  logic [DATA_W-1:0]     fwd_data_in,
  output logic [DATA_W-1:0]     op_1_out,
  output logic [DATA_W-1:0]     op_2_out,
  output logic [3:0]            opcode_out,
  output logic [4:0]            rd_addr_out,
  output logic                  wr_en_out,
  output logic                  illegal_out,
  output logic                  valid_out,
  input  logic                  ready_in
);
  logic [DATA_W-1:0] w_rs1, w_rs2, w_op1, w_op2, w_upper;
  logic [3:0]        w_opc;
  logic [2:0]        w_f3;
  logic              w_f7b, w_shift, w_illegal, w_accept;
  logic [DATA_W-1:0] r_op1, r_op2;
  logic [3:0]        r_opc;
  logic [4:0]        r_rd;
  logic              r_wr, r_ill, r_valid;
  assign w_f3     = instr_in[14:12];
  assign w_f7b    = instr_in[30];
  assign w_shift  = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  assign w_upper  = {instr_in[31:12], 12'b0};
  assign ready_out = !r_valid || ready_in;
  assign w_accept = valid_in && ready_out && !flush_in;
`ifdef ALU_OPERAND_FWD_EN
  always_comb begin
    w_rs1 = rs1_data_in;
    w_rs2 = rs2_data_in;
    if (fwd_valid_in && fwd_rd_in != '0 && fwd_rd_in == instr_in[19:15]) w_rs1 = fwd_data_in;
    if (fwd_valid_in && fwd_rd_in != '0 && fwd_rd_in == instr_in[24:20]) w_rs2 = fwd_data_in;
  end
`else
  logic w_unused;
  assign w_unused = ^{fwd_valid_in, fwd_rd_in, fwd_data_in};
  assign w_rs1 = rs1_data_in;
  assign w_rs2 = rs2_data_in;
`endif
  // The ALU shifts by the whole operand, so shift amounts are masked to 5 bits here.
  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_opc     = 4'b0000;
    w_illegal = 1'b0;
    case (instr_in[6:0])
      7'b0110011: begin
        if (instr_in[31] || (|instr_in[29:25])) w_illegal = 1'b1;
        else begin
          w_op1 = w_rs1;
          w_op2 = w_shift ? {{(DATA_W-5){1'b0}}, w_rs2[4:0]} : w_rs2;
          w_opc = {w_f7b, w_f3};
        end
      end
      7'b0010011: begin
        w_op1 = w_rs1;
        w_op2 = w_shift ? {{(DATA_W-5){1'b0}}, instr_in[24:20]} : {{(DATA_W-12){instr_in[31]}}, instr_in[31:20]};
        w_opc = {w_shift && w_f7b, w_f3};
      end
      7'b0110111: w_op2 = w_upper;
      7'b0010111: begin
        w_op1 = pc_in;
        w_op2 = w_upper;
      end
      default: w_illegal = 1'b1;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_valid <= 1'b0;
      r_op1   <= '0;
      r_op2   <= '0;
      r_opc   <= '0;
      r_rd    <= '0;
      r_wr    <= 1'b0;
      r_ill   <= 1'b0;
    end else if (flush_in) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_op1   <= w_op1;
      r_op2   <= w_op2;
      r_opc   <= w_opc;
      r_rd    <= instr_in[11:7];
      r_wr    <= !w_illegal && (instr_in[11:7] != 5'd0);
      r_ill   <= w_illegal;
    end else if (ready_in) begin
      r_valid <= 1'b0;
    end
  end
  assign valid_out   = r_valid;
  assign op_1_out    = r_op1;
  assign op_2_out    = r_op2;
  assign opcode_out  = r_opc;
  assign rd_addr_out = r_rd;
  assign wr_en_out   = r_wr;
  assign illegal_out = r_ill;
endmodule
